// File: rtl/booth_divider.sv
// Sequential unsigned restoring divider: WIDTH-bit quotient and remainder from a two-beat operand load.
// Latency: done pulses WIDTH+2 cycles after start is accepted (2 cycles for a zero divisor).
// No backpressure: start is sampled only in IDLE and ignored otherwise; results hold until the next start.
module booth_divider #(
    parameter int WIDTH = 16,
    parameter int CW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] Data_in,
    input  logic             rsel,
    output logic [WIDTH-1:0] Data_out,
    output logic             busy,
    output logic             done,
    output logic             dbz
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_M = 2'd1,
        CALC   = 2'd2,
        FIN    = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] q;        // dividend, shifted into the quotient
    logic [WIDTH:0]   a;        // partial remainder with sign bit
    logic [WIDTH-1:0] m;        // divisor
    logic [WIDTH-1:0] dvd;      // dividend shadow, read back as remainder on divide-by-zero
    logic [CW-1:0]    cnt;
    logic             dbz_r;

    logic [WIDTH:0]   t_a;      // upper half of {A,Q} shifted left by one
    logic [WIDTH:0]   diff;     // trial subtraction; bit WIDTH set means negative

    assign t_a  = {a[WIDTH-1:0], q[WIDTH-1]};
    assign diff = t_a - {1'b0, m};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: zero divisor skips the iterations and goes straight to FIN.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD_M;
            LOAD_M:  state_nxt = (Data_in == '0) ? FIN : CALC;
            CALC:    if (cnt == CW'(1)) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, one restoring iteration per CALC cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q     <= '0;
            a     <= '0;
            m     <= '0;
            dvd   <= '0;
            cnt   <= '0;
            dbz_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        q     <= Data_in;
                        dvd   <= Data_in;
                        a     <= '0;
                        dbz_r <= 1'b0;
                    end
                end
                LOAD_M: begin
                    m   <= Data_in;
                    cnt <= CW'(WIDTH);
                    if (Data_in == '0) begin
                        // Saturated quotient; remainder reads back as the dividend in FIN.
                        dbz_r <= 1'b1;
                        q     <= '1;
                        a     <= {1'b0, dvd};
                    end
                end
                CALC: begin
                    a   <= diff[WIDTH] ? t_a : diff;
                    q   <= {q[WIDTH-2:0], ~diff[WIDTH]};
                    cnt <= cnt - CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Status and result mux are pure decodes of the registered state.
    always_comb begin
        busy     = (state == LOAD_M) || (state == CALC);
        done     = (state == FIN);
        dbz      = dbz_r;
        Data_out = rsel ? a[WIDTH-1:0] : q;
    end

endmodule

// File: tb/tb_booth_divider.sv
// Testbench for booth_divider: directed boundary cases plus random back-to-back operations.
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected results come from plain integer division in the bench.
module tb_booth_divider;

    localparam int W = 16;

    logic         clk     = 1'b0;
    logic         rst     = 1'b0;
    logic         start   = 1'b0;
    logic         rsel    = 1'b0;
    logic [W-1:0] Data_in = '0;
    logic [W-1:0] Data_out;
    logic         busy;
    logic         done;
    logic         dbz;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int last_done = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    booth_divider #(.WIDTH(W), .CW(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .Data_in  (Data_in),
        .rsel     (rsel),
        .Data_out (Data_out),
        .busy     (busy),
        .done     (done),
        .dbz      (dbz)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full operation starting on the next falling edge; checks latency, busy, dbz and results.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit repulse, input bit spacing);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        int           exp_lat;
        int           lat;
        bit           busy_ok;
        if (b == 0) begin
            eq = '1; er = a; exp_lat = 2;
        end else begin
            eq = a / b; er = a % b; exp_lat = W + 2;
        end
        @(negedge clk);
        start = 1'b1; Data_in = a;
        @(negedge clk);
        busy_ok = (busy === 1'b1) && (done === 1'b0);
        start = 1'b0; Data_in = b;
        lat = -1;
        for (int c = 2; c < 60; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) begin
                lat = c;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            Data_in = W'($urandom);
            if (repulse && (c == 5 || c == 17)) start = 1'b1;
        end
        check("latency", lat, exp_lat);
        check("busy", busy_ok && (busy === 1'b0), 1);
        check("dbz", dbz, (b == 0));
        rsel = 1'b0; #1;
        check("quotient", Data_out, eq);
        rsel = 1'b1; #1;
        check("remainder", Data_out, er);
        rsel = 1'b0;
        if (spacing) check("done_spacing", cyc - last_done, 19);
        last_done = cyc;
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        // Reset state.
        #1;
        check("rst_q", Data_out, 0);
        rsel = 1'b1; #1;
        check("rst_r", Data_out, 0);
        rsel = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", dbz, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Basic operation and boundary operands.
        run_op(16'd100, 16'd7, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'd1, 1'b0, 1'b0);
        run_op(16'd3, 16'd10, 1'b0, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);

        // Divide by zero, then a normal op clears the flag.
        run_op(16'd5, 16'd0, 1'b0, 1'b0);
        rsel = 1'b1;
        @(negedge clk);
        check("dbz_hold_r", Data_out, 5);
        check("dbz_hold_flag", dbz, 1);
        rsel = 1'b0;
        run_op(16'd9, 16'd3, 1'b0, 1'b0);

        // Start re-pulsed mid-operation is ignored.
        run_op(16'd1000, 16'd33, 1'b1, 1'b0);
        @(negedge clk);
        check("no_restart_busy", busy, 0);
        check("no_restart_done", done, 0);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        start = 1'b1; Data_in = 16'd50000;
        @(negedge clk);
        start = 1'b0; Data_in = 16'd123;
        repeat (8) @(negedge clk);
        rst = 1'b0; #1;
        check("arst_q", Data_out, 0);
        rsel = 1'b1; #1;
        check("arst_r", Data_out, 0);
        rsel = 1'b0;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_dbz", dbz, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_op(16'd50000, 16'd123, 1'b0, 1'b0);

        // Random back-to-back operations.
        for (int i = 0; i < 100; i++) begin
            ra = W'($urandom);
            if (i % 4 == 1) rb = W'($urandom_range(1, 255));
            else            rb = W'($urandom_range(1, 65535));
            run_op(ra, rb, 1'b0, (i != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
